led_pattern_engine: RTL and testbench
=====================================

# led_pattern_engine

Parametrised running-LED pattern engine driving a WIDTH-bit LED bank from the board clock. It generates a programmable step tick and advances a loaded pattern by rotate-right, rotate-left or bounce (ping-pong), or holds it. An optional PWM stage dims all lit LEDs. It sits directly behind the board LED pins, and its control inputs come from switches or a register block.

## Interface
- WIDTH, 8: number of LEDs; minimum 2.
- DIV_W, 32: width of the step-period input.
- clock  in  1  system clock (100 MHz on board).
- reset  in  1  synchronous, active-high.
- init_state  in  WIDTH  pattern loaded on reset or load.
- load  in  1  single-cycle strobe that reloads init_state.
- mode  in  2  00 rotate right, 01 rotate left, 10 bounce, 11 hold.
- step_div  in  DIV_W  a step occurs every step_div+1 cycles; the board default is 99_999_999, giving 1 s.
- duty  in  4  brightness; present only with LED_PWM_EN.
- led  out  WIDTH  LED drive.
- step  out  1  one-cycle pulse, high in the cycle led takes a new pattern value.
- Reset and clock: reset reset, synchronous, active-high; clock clock.

## Operation
- **Divider.** `cnt` (DIV_W bits) increments every cycle.
  - When `cnt >= step_div`: `tick` is high and `cnt` clears to 0.
  - Using >= means that lowering `step_div` below the current `cnt` gives a tick on the next cycle, with no wrap-through.
  - `step_div = 0` gives a tick every cycle.
- **Pattern register `pat`.** Updates on `tick` when mode != 11.
  - Rotate right: `{pat[0], pat[WIDTH-1:1]}`.
  - Rotate left: `{pat[WIDTH-2:0], pat[WIDTH-1]}`.
- **Bounce FSM.** Two states, DIR_R and DIR_L; reset state is DIR_R.
  - On a tick in DIR_R: if `pat[0] = 1`, go to DIR_L and rotate left; otherwise rotate right.
  - On a tick in DIR_L: if `pat[WIDTH-1] = 1`, go to DIR_R and rotate right; otherwise rotate left.
  - The FSM state is retained while mode is not 10.
  - When entering bounce, the FSM resumes in its retained direction.
- **Hold (mode 11).** `pat` is frozen and `step` stays low. The divider keeps running.
- **Mode changes** take effect at the next tick; there is no re-phasing of the divider.
- **All-zero or all-one patterns** rotate to themselves. `step` still pulses on each tick.
- **Reset or load:**
  - `pat` <= init_state, `cnt` <= 0, FSM <= DIR_R, `step` <= 0.
  - `load` takes priority over a coincident tick; that tick is discarded.
  - `reset` takes priority over `load`.
- **Output.** Without PWM, `led = pat`.

## Timing
- All state is registered. `led` and `step` are registered outputs with no combinational input-to-output path.
- **Reset values:** `led = init_state` sampled at reset, `step = 0`, `cnt = 0`, FSM = DIR_R. With PWM, `led` is 0 until the first PWM on-phase.
- **First step** after reset or load is visible `step_div + 1` cycles later. Subsequent steps come every `step_div + 1` cycles.
- **Step latency.** `step` and the new `led` value appear together, 1 cycle after `cnt` reaches `step_div`.
- **Load latency.** `load` in cycle n gives `led = init_state` in cycle n+1.

## Configuration
- `LED_PWM_EN` defined:
  - The `duty` port exists.
  - A 4-bit free-running `pwm_cnt` runs; it clears on reset and is not affected by load.
  - `led = pat & {WIDTH{pwm_on}}`, where `pwm_on` is registered `pwm_cnt < duty`.
  - Duty 0 means dark; duty 15 means a 15/16 on-ratio.
  - This adds 1 cycle of latency on `led` relative to `step`.
- `LED_PWM_EN` undefined: no `duty` port, no `pwm_cnt`, `led = pat` at full brightness.

## Structure
- **Package `led_pkg`:**
  - Mode encodings `MODE_ROR`, `MODE_ROL`, `MODE_BOUNCE`, `MODE_HOLD`.
  - Direction enum `DIR_R`/`DIR_L`.
  - `PWM_W = 4`.
  - `BOARD_STEP_DIV = 99_999_999`.
- **Sub-module `step_divider`:** parameter DIV_W; inputs `clock`, `reset`, `clear` (driven by load), `step_div`; output `tick`. It is reused by other timed board blocks.

## Test plan
- **Rotate right.** WIDTH=8, step_div=3, mode=00, reset with init 0x01 → `led` = 0x80, 0x40, 0x20 at 4-cycle spacing; `step` pulses coincide.
- **Bounce.** mode=10, init 0x04, step_div=0 → `led` = 0x02, 0x01, 0x02, 0x04 … 0x80, 0x40; direction flips exactly at the edges.
- **Hold and load.** Hold for 10 cycles → `led` unchanged, `step` stays 0. Load 0xA5 coincident with a tick → `led` = 0xA5, that tick discarded, next step 4 cycles later.
- **Divider change.** `cnt` = 50, `step_div` changed to 10 → step occurs 1 cycle later, then every 11 cycles.
- **PWM.** `LED_PWM_EN`, init 0xFF, mode=11, duty=4 → `led` = 0xFF for 4 of every 16 cycles. duty=0 → `led` always 0x00.
- **Reset mid-bounce.** Reset while in DIR_L → `led` = init_state, next step rotates right.

Source files
------------

// File: rtl/led_pkg.sv
// ----------------------------------------------------------------------------
// led_pkg: shared mode encodings, bounce direction type and board constants.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package led_pkg;

  localparam logic [1:0] MODE_ROR    = 2'b00;
  localparam logic [1:0] MODE_ROL    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic {
    DIR_R = 1'b0,
    DIR_L = 1'b1
  } dir_t;

  localparam int PWM_W = 4;

  // 100 MHz board clock: one step per second.
  localparam logic [31:0] BOARD_STEP_DIV = 32'd99_999_999;

endpackage

`default_nettype wire

// File: rtl/step_divider.sv
// ----------------------------------------------------------------------------
// step_divider: programmable period tick, one pulse every step_div+1 cycles.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module step_divider #(
  parameter int DIV_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [DIV_W-1:0] step_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic             at_period;

  // >= rather than == so a shrinking period fires at once instead of wrapping.
  assign at_period = (cnt >= step_div);
  assign tick      = at_period && !clear;

  always_ff @(posedge clock) begin
    if (reset || clear || at_period) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_pattern_engine.sv
// ----------------------------------------------------------------------------
// led_pattern_engine: rotate/bounce/hold LED pattern engine; LED_PWM_EN adds
// a duty-controlled dimming stage and the duty port.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module led_pattern_engine
  import led_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] init_state,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] step_div,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0] duty,
`endif
  output logic [WIDTH-1:0] led,
  output logic             step
);

  logic             tick;
  logic [WIDTH-1:0] pat;
  logic [WIDTH-1:0] pat_next;
  logic [WIDTH-1:0] pat_ror;
  logic [WIDTH-1:0] pat_rol;
  dir_t             dir;
  dir_t             dir_next;

  step_divider #(
    .DIV_W (DIV_W)
  ) u_step_divider (
    .clock    (clock),
    .reset    (reset),
    .clear    (load),
    .step_div (step_div),
    .tick     (tick)
  );

  assign pat_ror = {pat[0], pat[WIDTH-1:1]};
  assign pat_rol = {pat[WIDTH-2:0], pat[WIDTH-1]};

  // Bounce direction register; retained across non-bounce modes.
  always_ff @(posedge clock) begin
    if (reset || load) begin
      dir <= DIR_R;
    end else begin
      dir <= dir_next;
    end
  end

  always_comb begin
    dir_next = dir;
    pat_next = pat;
    if (tick) begin
      case (mode)
        MODE_ROR: pat_next = pat_ror;
        MODE_ROL: pat_next = pat_rol;
        MODE_BOUNCE: begin
          if (dir == DIR_R) begin
            if (pat[0]) begin
              dir_next = DIR_L;
              pat_next = pat_rol;
            end else begin
              pat_next = pat_ror;
            end
          end else begin
            if (pat[WIDTH-1]) begin
              dir_next = DIR_R;
              pat_next = pat_ror;
            end else begin
              pat_next = pat_rol;
            end
          end
        end
        default: pat_next = pat;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || load) begin
      pat  <= init_state;
      step <= 1'b0;
    end else begin
      pat  <= pat_next;
      step <= tick && (mode != MODE_HOLD);
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;
  logic             pwm_on;

  // The PWM phase ignores load so brightness stays steady across reloads.
  always_ff @(posedge clock) begin
    if (reset) begin
      pwm_cnt <= '0;
      pwm_on  <= 1'b0;
      led     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pwm_on  <= (pwm_cnt < duty);
      led     <= pat & {WIDTH{pwm_on}};
    end
  end
`else
  assign led = pat;
`endif

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_engine.sv
// ----------------------------------------------------------------------------
// tb_led_pattern_engine: directed checks of rotate, hold, load, divider
// change, bounce and reset behaviour (default build).  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_led_pattern_engine;

  localparam int WIDTH = 8;
  localparam int DIV_W = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] init_state;
  logic             load;
  logic [1:0]       mode;
  logic [DIV_W-1:0] step_div;
  logic [WIDTH-1:0] led;
  logic             step;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_ror [0:3] = '{8'h01, 8'h80, 8'h40, 8'h20};
  logic [7:0] exp_bnc [0:17] = '{8'h02, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h40, 8'h20, 8'h10,
                                 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

  led_pattern_engine #(
    .WIDTH (WIDTH),
    .DIV_W (DIV_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .init_state (init_state),
    .load       (load),
    .mode       (mode),
    .step_div   (step_div),
    .led        (led),
    .step       (step)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with init 0x01, rotate right every 4 cycles
    reset = 1'b1; load = 1'b0; init_state = 8'h01; mode = 2'b00; step_div = 3;
    cyc();
    cyc();
    chk("reset_led", led, 8'h01);
    chk("reset_step", {7'b0, step}, 8'h00);
    reset = 1'b0;

    for (int i = 1; i <= 12; i++) begin
      cyc();
      chk("ror_led", led, exp_ror[i / 4]);
      chk("ror_step", {7'b0, step}, {7'b0, (i % 4 == 0)});
    end

    // Hold for 10 cycles: frozen pattern, no step
    mode = 2'b11;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk("hold_led", led, 8'h20);
      chk("hold_step", {7'b0, step}, 8'h00);
    end
    mode = 2'b00;
    cyc();
    chk("pre_load_led", led, 8'h20);

    // Load coincident with a tick: tick discarded, next step 4 cycles on
    load = 1'b1; init_state = 8'hA5;
    cyc();
    chk("load_led", led, 8'hA5);
    chk("load_step", {7'b0, step}, 8'h00);
    load = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("post_load_led", led, 8'hA5);
      chk("post_load_step", {7'b0, step}, 8'h00);
    end
    cyc();
    chk("post_load_first_led", led, 8'hD2);
    chk("post_load_first_step", {7'b0, step}, 8'h01);

    // Long period, then shrink it while cnt = 50
    step_div = 100;
    for (int i = 1; i <= 50; i++) begin
      cyc();
      chk("long_div_step", {7'b0, step}, 8'h00);
    end
    chk("long_div_led", led, 8'hD2);
    step_div = 10;
    cyc();
    chk("shrink_led", led, 8'h69);
    chk("shrink_step", {7'b0, step}, 8'h01);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk("shrink_gap_step", {7'b0, step}, 8'h00);
    end
    cyc();
    chk("shrink_next_led", led, 8'hB4);
    chk("shrink_next_step", {7'b0, step}, 8'h01);

    // Bounce from 0x04 at one step per cycle
    mode = 2'b10; step_div = 0; init_state = 8'h04; load = 1'b1;
    cyc();
    chk("bounce_load_led", led, 8'h04);
    chk("bounce_load_step", {7'b0, step}, 8'h00);
    load = 1'b0;
    for (int i = 0; i < 18; i++) begin
      cyc();
      chk("bounce_led", led, exp_bnc[i]);
      chk("bounce_step", {7'b0, step}, 8'h01);
    end

    // Reset while moving left: next step must go right
    reset = 1'b1; init_state = 8'h10;
    cyc();
    chk("midreset_led", led, 8'h10);
    chk("midreset_step", {7'b0, step}, 8'h00);
    reset = 1'b0;
    cyc();
    chk("midreset_next_led", led, 8'h08);
    chk("midreset_next_step", {7'b0, step}, 8'h01);

    // Rotate left
    mode = 2'b01;
    cyc();
    chk("rol_led_1", led, 8'h10);
    cyc();
    chk("rol_led_2", led, 8'h20);

    // All-ones pattern rotates to itself but still steps
    load = 1'b1; init_state = 8'hFF; mode = 2'b00;
    cyc();
    chk("ones_load_led", led, 8'hFF);
    chk("ones_load_step", {7'b0, step}, 8'h00);
    load = 1'b0;
    cyc();
    chk("ones_led", led, 8'hFF);
    chk("ones_step", {7'b0, step}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
